aes_precomp_sched: RTL and testbench
====================================

Name: aes_precomp_sched

Overview:
Block-level controller that sequences the masked S-box table precompute engine and the round datapath for one AES block at a time. It accepts block requests, fetches fresh 128-bit combined masks from the PRNG, starts and waits on table precompute, then issues round-step handshakes. Tables are reused across blocks of the same direction until a remask budget is used up or a flush occurs.

Parameters:
REMASK_BLOCKS, 1, blocks served per table fill before forced remask/refill (legal range 1..255).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid_i  in  1  block request valid
req_ready_o  out  1  request accepted when valid&ready
req_enc_dec_i  in  1  0=ENC, 1=DEC
req_key_len_i  in  2  0=AES-128, 1=AES-192, 2=AES-256, 3=treated as 0
flush_i  in  1  invalidate current tables
prng_req_o  out  1  mask request, held until ack
prng_ack_i  in  1  prng_data_i valid this cycle
prng_data_i  in  128  fresh mask, byte j = bits [8j+7:8j]
pc_start_o  out  1  one-cycle precompute start pulse
pc_enc_dec_o  out  1  direction to precompute engine
pc_done_i  in  1  precompute engine done (combinational, high when idle)
mc_o  out  8x16  combined mask per byte position, registered
rnd_valid_o  out  1  round-step request
rnd_ready_i  in  1  datapath accepts round step
rnd_idx_o  out  4  round index 0..Nr
rnd_last_o  out  1  rnd_idx_o == Nr
done_o  out  1  one-cycle pulse, block complete
busy_o  out  1  state != IDLE

Behaviour:
- States: IDLE, MASK, PC_START, PC_WAIT, ROUND, DONE.
- Reset values: state=IDLE, req_ready_o=1, all other outputs 0, mc_o all 0, tbl_valid=0, tbl_dir=0, use_cnt=0, rnd_idx=0.
- IDLE: req_ready_o=1. On accept, latch enc_dec and Nr (10/12/14 for key_len 0/1/2; 10 for key_len 3).
  - If tbl_valid && tbl_dir==enc_dec && use_cnt<REMASK_BLOCKS, go to ROUND (reuse).
  - Otherwise go to MASK.
- MASK: prng_req_o=1. On prng_ack_i, mc_o<=prng_data_i bytes, prng_req_o deasserts next cycle, go to PC_START. An ack outside MASK is ignored.
- PC_START: pc_start_o=1 for exactly one cycle. pc_enc_dec_o = latched direction, held stable from PC_START through PC_WAIT. Set tbl_valid=0, then go to PC_WAIT.
- PC_WAIT: pc_done_i is ignored in the first PC_WAIT cycle (one-cycle blanking, because the engine's done is combinational). From the second cycle, pc_done_i=1 sets tbl_valid=1, tbl_dir=direction, use_cnt=0, and goes to ROUND.
- ROUND: rnd_valid_o=1 with rnd_idx_o starting at 0.
  - On rnd_valid_o&rnd_ready_i: if idx==Nr, go to DONE; else idx+1 and rnd_valid_o stays high.
  - idx, last and valid are stable while ready is low.
  - Nr+1 handshakes per block; minimum one cycle each.
- DONE: done_o=1 for one cycle; use_cnt saturating +1 (8-bit internal); idx<=0; go to IDLE.
- mc_o changes only in MASK on ack; stable through precompute and all rounds.
- flush_i:
  - In IDLE or DONE: tbl_valid<=0 next cycle.
  - In other states: latched as flush_pend, and tbl_valid clears on entering IDLE. The in-flight block completes normally.
  - Flush on the same cycle as a request accept: the flush wins, so that request takes the MASK path.
- Latency, reuse path: accept -> first rnd_valid_o in 1 cycle.
- Latency, fill path: accept -> prng_req_o next cycle; ack -> pc_start_o next cycle.
- Reset mid-operation: immediate return to reset values. Tables are considered invalid.

Test Plan:
- Reset, then ENC AES-128 request, ack after 2 cycles with data 0x0F0E..00, pc_done low 16 cycles, rnd_ready=1 -> one pc_start pulse, mc_o[0]=0x00, mc_o[15]=0x0F, 11 round handshakes idx 0..10, rnd_last only on idx 10, one done pulse.
- REMASK_BLOCKS=2, three back-to-back ENC blocks -> block 2 has no prng_req and no pc_start; block 3 remasks and refills.
- ENC block then DEC block -> DEC triggers MASK+PC_START, pc_enc_dec_o=1; AES-256 DEC yields 15 handshakes.
- pc_done_i tied high throughout -> controller still spends ≥1 PC_WAIT cycle; rnd_valid_o rises no earlier than 2 cycles after pc_start_o.
- flush_i pulsed during ROUND of block 1, REMASK_BLOCKS=4 -> block 1 completes; block 2 refetches masks.
- rnd_ready low for 5 cycles at idx 3; rst_n asserted in PC_WAIT -> idx/valid held during stall; on reset, all outputs return to reset values and the next request takes the MASK path.

Source files
------------

// File: rtl/aes_precomp_sched.sv
// Block-level sequencer for the masked S-box table precompute engine and the AES round datapath.
// Tables are reused across same-direction blocks until the remask budget runs out or a flush arrives.
module aes_precomp_sched #(
  parameter int unsigned REMASK_BLOCKS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_enc_dec_i,
  input  logic [1:0]       req_key_len_i,
  input  logic             flush_i,
  output logic             prng_req_o,
  input  logic             prng_ack_i,
  input  logic [127:0]     prng_data_i,
  output logic             pc_start_o,
  output logic             pc_enc_dec_o,
  input  logic             pc_done_i,
  output logic [15:0][7:0] mc_o,
  output logic             rnd_valid_o,
  input  logic             rnd_ready_i,
  output logic [3:0]       rnd_idx_o,
  output logic             rnd_last_o,
  output logic             done_o,
  output logic             busy_o
);

  typedef enum logic [2:0] {
    IDLE,
    MASK,
    PC_START,
    PC_WAIT,
    ROUND,
    DONE
  } state_t;

  localparam logic [7:0] REMASK_LIMIT = 8'(REMASK_BLOCKS);

  state_t     state;
  logic       tbl_valid;
  logic       tbl_dir;
  logic       dir;
  logic       flush_pend;
  logic       wait_first;
  logic [7:0] use_cnt;
  logic [3:0] nr;

  logic [3:0] nr_req;
  logic       reuse_ok;

  // Key length 3 is not a real AES variant and falls back to the AES-128 round count.
  always_comb begin
    case (req_key_len_i)
      2'd1:    nr_req = 4'd12;
      2'd2:    nr_req = 4'd14;
      default: nr_req = 4'd10;
    endcase
  end

  // A flush arriving with the request must force a refill, so it vetoes reuse here.
  assign reuse_ok = tbl_valid && (tbl_dir == req_enc_dec_i) &&
                    (use_cnt < REMASK_LIMIT) && !flush_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      req_ready_o  <= 1'b1;
      prng_req_o   <= 1'b0;
      pc_start_o   <= 1'b0;
      pc_enc_dec_o <= 1'b0;
      mc_o         <= '0;
      rnd_valid_o  <= 1'b0;
      rnd_idx_o    <= 4'd0;
      rnd_last_o   <= 1'b0;
      done_o       <= 1'b0;
      busy_o       <= 1'b0;
      tbl_valid    <= 1'b0;
      tbl_dir      <= 1'b0;
      dir          <= 1'b0;
      flush_pend   <= 1'b0;
      wait_first   <= 1'b0;
      use_cnt      <= 8'd0;
      nr           <= 4'd10;
    end else begin
      // Flushes seen mid-block are deferred; IDLE and DONE override this below.
      if (flush_i) flush_pend <= 1'b1;

      case (state)
        IDLE: begin
          flush_pend <= 1'b0;
          if (flush_i) tbl_valid <= 1'b0;
          if (req_valid_i) begin
            dir         <= req_enc_dec_i;
            nr          <= nr_req;
            req_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            if (reuse_ok) begin
              state       <= ROUND;
              rnd_valid_o <= 1'b1;
              rnd_idx_o   <= 4'd0;
              rnd_last_o  <= 1'b0;
            end else begin
              state      <= MASK;
              prng_req_o <= 1'b1;
            end
          end
        end

        MASK: begin
          if (prng_ack_i) begin
            // Byte j of the PRNG word lands in mc_o[j].
            mc_o         <= prng_data_i;
            prng_req_o   <= 1'b0;
            pc_start_o   <= 1'b1;
            pc_enc_dec_o <= dir;
            state        <= PC_START;
          end
        end

        PC_START: begin
          pc_start_o <= 1'b0;
          tbl_valid  <= 1'b0;
          wait_first <= 1'b1;
          state      <= PC_WAIT;
        end

        PC_WAIT: begin
          // The engine's done is combinational and may still read high right after start.
          if (wait_first) begin
            wait_first <= 1'b0;
          end else if (pc_done_i) begin
            tbl_valid   <= 1'b1;
            tbl_dir     <= dir;
            use_cnt     <= 8'd0;
            state       <= ROUND;
            rnd_valid_o <= 1'b1;
            rnd_idx_o   <= 4'd0;
            rnd_last_o  <= 1'b0;
          end
        end

        ROUND: begin
          if (rnd_ready_i) begin
            if (rnd_idx_o == nr) begin
              rnd_valid_o <= 1'b0;
              rnd_last_o  <= 1'b0;
              done_o      <= 1'b1;
              state       <= DONE;
            end else begin
              rnd_idx_o  <= rnd_idx_o + 4'd1;
              rnd_last_o <= ((rnd_idx_o + 4'd1) == nr);
            end
          end
        end

        DONE: begin
          done_o      <= 1'b0;
          rnd_idx_o   <= 4'd0;
          req_ready_o <= 1'b1;
          busy_o      <= 1'b0;
          state       <= IDLE;
          if (use_cnt != 8'hFF) use_cnt <= use_cnt + 8'd1;
          if (flush_pend || flush_i) tbl_valid <= 1'b0;
          flush_pend <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_precomp_sched.sv
// Randomized self-checking bench for aes_precomp_sched against a block-level table-reuse model.
module tb_aes_precomp_sched;

  localparam int REMASK = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic             req_enc_dec = 1'b0;
  logic [1:0]       req_key_len = 2'd0;
  logic             flush = 1'b0;
  logic             prng_req;
  logic             prng_ack = 1'b0;
  logic [127:0]     prng_data = '0;
  logic             pc_start;
  logic             pc_enc_dec;
  logic             pc_done = 1'b1;
  logic [15:0][7:0] mc;
  logic             rnd_valid;
  logic             rnd_ready = 1'b0;
  logic [3:0]       rnd_idx;
  logic             rnd_last;
  logic             done;
  logic             busy;

  aes_precomp_sched #(.REMASK_BLOCKS(REMASK)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_enc_dec_i(req_enc_dec),
    .req_key_len_i(req_key_len),
    .flush_i      (flush),
    .prng_req_o   (prng_req),
    .prng_ack_i   (prng_ack),
    .prng_data_i  (prng_data),
    .pc_start_o   (pc_start),
    .pc_enc_dec_o (pc_enc_dec),
    .pc_done_i    (pc_done),
    .mc_o         (mc),
    .rnd_valid_o  (rnd_valid),
    .rnd_ready_i  (rnd_ready),
    .rnd_idx_o    (rnd_idx),
    .rnd_last_o   (rnd_last),
    .done_o       (done),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model of the table cache: validity, direction and blocks served since fill.
  logic         m_valid = 1'b0;
  logic         m_dir = 1'b0;
  int           m_uses = 0;
  logic [127:0] mc_exp = '0;
  logic [127:0] next_data = '0;

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_req_ready"}, req_ready, 1'b1);
    checkOutput({tag, "_prng_req"}, prng_req, 1'b0);
    checkOutput({tag, "_pc_start"}, pc_start, 1'b0);
    checkOutput({tag, "_pc_dir"}, pc_enc_dec, 1'b0);
    checkOutput({tag, "_mc"}, mc, '0);
    checkOutput({tag, "_rnd_valid"}, rnd_valid, 1'b0);
    checkOutput({tag, "_rnd_idx"}, rnd_idx, 4'd0);
    checkOutput({tag, "_rnd_last"}, rnd_last, 1'b0);
    checkOutput({tag, "_done"}, done, 1'b0);
    checkOutput({tag, "_busy"}, busy, 1'b0);
  endtask

  task automatic flushIdle();
    flush = 1'b1;
    step();
    flush = 1'b0;
    m_valid = 1'b0;
    checkOutput("idle_flush_ready", req_ready, 1'b1);
  endtask

  // Runs one block end to end, playing PRNG, precompute engine and round datapath.
  task automatic applyStimulus(input logic dir, input logic [1:0] kl, input int ack_delay,
                               input int pc_delay, input int stall_idx, input int stall_len,
                               input int flush_idx, input logic flush_on_accept,
                               input logic reset_in_wait, input int drop_pct);
    int nr, exp_idx, stall_cnt, starts, dones, req_first, ack_at, start_at;
    logic fill, flushed, ack_sent, seen_valid;
    nr = (kl == 2'd1) ? 12 : (kl == 2'd2) ? 14 : 10;
    checkOutput("idle_ready", req_ready, 1'b1);
    if (flush_on_accept) m_valid = 1'b0;
    fill = !(m_valid && m_dir == dir && m_uses < REMASK);

    req_valid = 1'b1; req_enc_dec = dir; req_key_len = kl; flush = flush_on_accept;
    step();
    req_valid = 1'b0; flush = 1'b0;
    checkOutput("accept_ready_low", req_ready, 1'b0);
    checkOutput("accept_busy", busy, 1'b1);
    checkOutput("lat_prng_req", prng_req, fill);
    checkOutput("lat_rnd_valid", rnd_valid, !fill);

    exp_idx = 0; stall_cnt = 0; starts = 0; dones = 0;
    req_first = -1; ack_at = -10; start_at = -1;
    flushed = 1'b0; ack_sent = 1'b0; seen_valid = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      prng_ack = 1'b0;
      flush = 1'b0;
      if (prng_req && !ack_sent) begin
        if (req_first < 0) req_first = cyc;
        if (cyc - req_first >= ack_delay) begin
          prng_ack = 1'b1; prng_data = next_data; ack_sent = 1'b1; ack_at = cyc;
        end
      end
      if (ack_sent && cyc == ack_at + 1) begin
        checkOutput("ack_to_start", pc_start, 1'b1);
        checkOutput("req_dropped", prng_req, 1'b0);
      end
      if (pc_start) begin
        starts++;
        start_at = cyc;
        checkOutput("pc_dir", pc_enc_dec, dir);
        checkOutput("mc_load", mc, next_data);
        mc_exp = next_data;
      end
      if (start_at >= 0 && cyc == start_at + 1) begin
        checkOutput("pc_dir_hold", pc_enc_dec, dir);
        if (reset_in_wait) begin
          rst_n = 1'b0;
          #1;
          checkResetValues("midrst");
          pc_done = 1'b1; rnd_ready = 1'b0;
          step();
          rst_n = 1'b1;
          step();
          checkResetValues("postrst");
          m_valid = 1'b0;
          mc_exp = '0;
          return;
        end
      end
      // Stale high done in the first wait cycle must be ignored by the controller.
      pc_done = (start_at < 0 || cyc <= start_at + 1) ? 1'b1 : (cyc - start_at - 2 >= pc_delay);
      if (rnd_valid) begin
        if (!seen_valid && fill) checkOutput("pc_to_round", cyc - start_at, 3 + pc_delay);
        seen_valid = 1'b1;
        checkOutput("rnd_idx", rnd_idx, exp_idx[3:0]);
        checkOutput("rnd_last", rnd_last, exp_idx == nr);
        checkOutput("busy_round", busy, 1'b1);
        if (flush_idx >= 0 && exp_idx == flush_idx && !flushed) begin
          flush = 1'b1; flushed = 1'b1;
        end
        if ($urandom_range(9) == 0) begin
          prng_ack = 1'b1; prng_data = {$urandom, $urandom, $urandom, $urandom};
        end
        if (exp_idx == stall_idx && stall_cnt < stall_len) begin
          rnd_ready = 1'b0; stall_cnt++;
        end else begin
          rnd_ready = ($urandom_range(99) >= drop_pct);
        end
        if (rnd_ready) exp_idx++;
      end else begin
        rnd_ready = $urandom_range(1) == 1;
      end
      if (done) begin
        dones++;
        checkOutput("done_after_last", exp_idx, nr + 1);
        checkOutput("mc_stable", mc, mc_exp);
        break;
      end
      step();
    end
    prng_ack = 1'b0; flush = 1'b0; rnd_ready = 1'b0; pc_done = 1'b1;
    checkOutput("block_done", dones, 1);
    checkOutput("pc_start_count", starts, fill);
    step();
    checkOutput("done_pulse", done, 1'b0);
    checkOutput("back_idle_ready", req_ready, 1'b1);
    checkOutput("back_idle_busy", busy, 1'b0);
    checkOutput("back_idle_valid", rnd_valid, 1'b0);
    if (fill) begin
      m_valid = 1'b1; m_dir = dir; m_uses = 1;
    end else begin
      m_uses++;
    end
    if (flushed) m_valid = 1'b0;
  endtask

  initial begin
    logic dir;
    logic [1:0] kl;
    for (int j = 0; j < 16; j++) next_data[8*j +: 8] = 8'(j);
    step();
    step();
    checkResetValues("reset");
    rst_n = 1'b1;
    step();
    checkResetValues("after_reset");

    applyStimulus(1'b0, 2'd0, 2, 16, -1, 0, -1, 1'b0, 1'b0, 0);
    checkOutput("mc_byte0", mc[0], 8'h00);
    checkOutput("mc_byte15", mc[15], 8'h0F);
    next_data = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(1'b0, 2'd0, 1, 3, -1, 0, -1, 1'b0, 1'b0, 0);
    next_data = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(1'b0, 2'd1, 0, 2, -1, 0, -1, 1'b0, 1'b0, 10);
    next_data = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(1'b1, 2'd2, 1, 4, -1, 0, -1, 1'b0, 1'b0, 0);
    next_data = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(1'b0, 2'd0, 0, 0, 3, 5, -1, 1'b0, 1'b0, 0);
    applyStimulus(1'b0, 2'd3, 0, 0, -1, 0, 4, 1'b0, 1'b0, 0);
    next_data = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(1'b0, 2'd0, 2, 1, -1, 0, -1, 1'b0, 1'b0, 0);
    next_data = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(1'b1, 2'd2, 1, 6, -1, 0, -1, 1'b0, 1'b1, 0);
    next_data = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(1'b1, 2'd0, 0, 1, -1, 0, -1, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 2'd0, 0, 1, -1, 0, -1, 1'b1, 1'b0, 0);

    for (int b = 0; b < 30; b++) begin
      if ($urandom_range(9) == 0) flushIdle();
      dir = ($urandom_range(3) == 0);
      kl = 2'($urandom_range(3));
      next_data = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(dir, kl, $urandom_range(3), $urandom_range(4),
                    ($urandom_range(4) == 0) ? int'($urandom_range(9)) : -1, $urandom_range(4),
                    ($urandom_range(6) == 0) ? int'($urandom_range(9)) : -1,
                    $urandom_range(19) == 0, 1'b0, 25);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
